// File: rtl/arm_pkg.sv
// Shared ARM execute-stage constants: shifter-operand field layout and shift types.
package arm_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SHOP_W    = 12;

  localparam int unsigned IMM8_LSB  = 0;
  localparam int unsigned IMM8_W    = 8;
  localparam int unsigned ROT_LSB   = 8;
  localparam int unsigned ROT_W     = 4;
  localparam int unsigned SHAMT_LSB = 7;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned STYPE_LSB = 5;
  localparam int unsigned STYPE_W   = 2;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

endpackage

// File: rtl/val2_shifter.sv
// Combinational 32-bit barrel shifter (LSL/LSR/ASR/ROR by 0..31).
module val2_shifter
  import arm_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [1:0]         shift_type,
  output logic [DATA_W-1:0]  result
);

  logic [2*DATA_W-1:0] rot_wide;

  always_comb begin
    rot_wide = {data, data} >> amount;
    result   = data;
    case (shift_type)
      SHIFT_LSL: result = data << amount;
      SHIFT_LSR: result = data >> amount;
      SHIFT_ASR: result = DATA_W'($signed(data) >>> amount);
      SHIFT_ROR: result = rot_wide[DATA_W-1:0];
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/va2_gen.sv
// Val2 generator: selects load/store offset, rotated immediate or shifted Rm,
// and registers the result (one-cycle latency).
module va2_gen
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] reg2,
  output logic [31:0] val2
);

  logic [DATA_W-1:0]  sh_data;
  logic [SHAMT_W-1:0] sh_amt;
  logic [1:0]         sh_type;
  logic [DATA_W-1:0]  sh_result;
  logic [DATA_W-1:0]  val2_d;
  logic [DATA_W-1:0]  val2_q;

  // One shifter serves both the immediate rotate and the register shift.
  always_comb begin
    sh_data = reg2;
    sh_amt  = shift_operand[SHAMT_LSB +: SHAMT_W];
    sh_type = shift_operand[STYPE_LSB +: STYPE_W];
    if (imm) begin
      sh_data = DATA_W'(shift_operand[IMM8_LSB +: IMM8_W]);
      sh_amt  = {shift_operand[ROT_LSB +: ROT_W], 1'b0};
      sh_type = SHIFT_ROR;
    end
  end

  val2_shifter u_shifter (
    .data       (sh_data),
    .amount     (sh_amt),
    .shift_type (sh_type),
    .result     (sh_result)
  );

  // Memory access wins over the immediate flag, which may be undefined then.
  always_comb begin
    val2_d = sh_result;
    if (mem_read | mem_write) begin
      val2_d = DATA_W'(shift_operand);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val2_q <= '0;
    end else begin
      val2_q <= val2_d;
    end
  end

  assign val2 = val2_q;

endmodule

// File: tb/tb_va2_gen.sv
// Scoreboard bench for va2_gen: directed vectors then randomized traffic.
module tb_va2_gen;

  logic        clk;
  logic        rst;
  logic [11:0] shift_operand;
  logic        imm;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] reg2;
  logic [31:0] val2;

  int unsigned checks;
  int unsigned errors;
  logic [31:0] exp_q[$];
  string       name_q[$];

  va2_gen dut (
    .clk           (clk),
    .rst           (rst),
    .shift_operand (shift_operand),
    .imm           (imm),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg2          (reg2),
    .val2          (val2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit-at-a-time rotate/shift straight from the operand rules.
  function automatic logic [31:0] model(input logic r, input logic mr, input logic mw,
                                        input logic im, input logic [11:0] so,
                                        input logic [31:0] r2);
    logic [31:0] v;
    int          n;
    if (r) return 32'h0;
    if (mr || mw) return {20'h0, so};
    if (im) begin
      v = {24'h0, so[7:0]};
      n = 2 * int'(so[11:8]);
      for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
      return v;
    end
    v = r2;
    n = int'(so[11:7]);
    for (int i = 0; i < n; i++) begin
      case (so[6:5])
        2'b00:   v = {v[30:0], 1'b0};
        2'b01:   v = {1'b0, v[31:1]};
        2'b10:   v = {v[31], v[31:1]};
        default: v = {v[0], v[31:1]};
      endcase
    end
    return v;
  endfunction

  task automatic drive(input string nm, input logic r, input logic mr, input logic mw,
                       input logic im, input logic [11:0] so, input logic [31:0] r2);
    rst           = r;
    mem_read      = mr;
    mem_write     = mw;
    imm           = im;
    shift_operand = so;
    reg2          = r2;
    exp_q.push_back(model(r, mr, mw, im, so, r2));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_chk(input string nm, input logic r, input logic mr, input logic mw,
                           input logic im, input logic [11:0] so, input logic [31:0] r2,
                           input logic [31:0] golden);
    // Directed vectors also cross-check the model against hand-derived values.
    logic [31:0] m;
    m = model(r, mr, mw, im, so, r2);
    checks++;
    if (m !== golden) begin
      errors++;
      $display("FAIL model_%s: model=%h required=%h", nm, m, golden);
    end
    drive(nm, r, mr, mw, im, so, r2);
  endtask

  // Monitor: val2 is valid every cycle; compare one expected value per clock.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (val2 !== e) begin
        errors++;
        $display("FAIL %s: val2=%h expected=%h", nm, val2, e);
      end
    end
  end

  localparam logic [31:0] R2 = 32'hA892_3142;

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; imm = 1'b0;
    shift_operand = 12'h0; reg2 = R2;
    checks = 0; errors = 0;
    #2;
    drive_chk("reset",     1'b1, 1'b0, 1'b0, 1'b0,  12'hA2D, R2, 32'h0000_0000);
    drive_chk("str_off",   1'b0, 1'b0, 1'b1, 1'bx,  12'hA2D, R2, 32'h0000_0A2D);
    drive_chk("ldr_off",   1'b0, 1'b1, 1'b0, 1'bx,  12'hA2D, R2, 32'h0000_0A2D);
    drive_chk("both_mem",  1'b0, 1'b1, 1'b1, 1'b1,  12'hA6D, R2, 32'h0000_0A6D);
    drive_chk("lsr20",     1'b0, 1'b0, 1'b0, 1'b0,  12'hA2D, R2, 32'h0000_0A89);
    drive_chk("asr20",     1'b0, 1'b0, 1'b0, 1'b0,  12'hA4D, R2, 32'hFFFF_FA89);
    drive_chk("ror20",     1'b0, 1'b0, 1'b0, 1'b0,  12'hA6D, R2, 32'h2314_2A89);
    drive_chk("lsl4",      1'b0, 1'b0, 1'b0, 1'b0,  12'h200, R2, 32'h8923_1420);
    drive_chk("amt0",      1'b0, 1'b0, 1'b0, 1'b0,  12'h000, R2, 32'hA892_3142);
    drive_chk("asr0",      1'b0, 1'b0, 1'b0, 1'b0,  12'h040, R2, 32'hA892_3142);
    drive_chk("lsl31",     1'b0, 1'b0, 1'b0, 1'b0,  12'hF80, R2, 32'h0000_0000);
    drive_chk("asr31",     1'b0, 1'b0, 1'b0, 1'b0,  12'hFC0, R2, 32'hFFFF_FFFF);
    drive_chk("imm_ror20", 1'b0, 1'b0, 1'b0, 1'b1,  12'hA6D, R2, 32'h0006_D000);
    drive_chk("imm_ror0",  1'b0, 1'b0, 1'b0, 1'b1,  12'h0FF, R2, 32'h0000_00FF);
    drive_chk("imm_ror2",  1'b0, 1'b0, 1'b0, 1'b1,  12'h1FF, R2, 32'hC000_003F);
    drive_chk("imm_ror30", 1'b0, 1'b0, 1'b0, 1'b1,  12'hF81, R2, 32'h0000_0204);
    drive_chk("pre_rst",   1'b0, 1'b0, 1'b0, 1'b0,  12'hA6D, R2, 32'h2314_2A89);
    drive_chk("mid_rst",   1'b1, 1'b0, 1'b0, 1'b0,  12'hA6D, R2, 32'h0000_0000);
    drive_chk("post_rst",  1'b0, 1'b0, 1'b0, 1'b0,  12'hA6D, R2, 32'h2314_2A89);

    for (int i = 0; i < 400; i++) begin
      logic r, mr, mw, im;
      r  = ($urandom_range(0, 19) == 0);
      mr = ($urandom_range(0, 5) == 0);
      mw = ($urandom_range(0, 5) == 0);
      im = 1'($urandom_range(0, 1));
      drive("rand", r, mr, mw, im, 12'($urandom), $urandom);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/va2_gen.md
# va2_gen

Second-operand (Val2) generator for the ARM execute stage. From the 12-bit shifter operand field, the immediate flag, the memory-access flags and the Rm register value, it produces the 32-bit second ALU operand: a zero-extended load/store offset, a rotated 8-bit immediate, or an immediate-shifted register. The result is registered, so Val2 is valid one clock after its inputs.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- shift_operand  in  12  instruction bits [11:0].
- imm  in  1  I bit: 1 = rotated immediate, 0 = shifted register.
- mem_read  in  1  LDR in execute.
- mem_write  in  1  STR in execute.
- reg2  in  32  Rm value, already forwarded.
- val2  out  32  registered second operand.

## Operation
- Selection priority, evaluated each cycle:
  1. mem_read | mem_write: result = {20'b0, shift_operand[11:0]}, the unsigned offset. imm is ignored and may be X.
  2. else imm = 1: imm8 = shift_operand[7:0] and rot = shift_operand[11:8]; result = {24'b0, imm8} rotated right by 2*rot, giving an amount of 0..30.
  3. else: amt = shift_operand[11:7] (0..31) and type = shift_operand[6:5]; result = reg2 shifted by amt:
     - 00 LSL: zero fill.
     - 01 LSR: zero fill.
     - 10 ASR: fill with reg2[31].
     - 11 ROR: 32-bit rotate right.
- shift_operand[4] (register-specified shift) is not supported and is ignored. shift_operand[3:0] (Rm index) is ignored because reg2 is supplied directly.
- amt = 0 passes reg2 through unchanged for every type. There is no LSR/ASR #32 and no RRX encoding.
- All arithmetic is 32-bit, with no carry-out generated. Any X/Z on the selected path propagates. X on an unselected input must not corrupt the result.

## Timing
- Single-cycle latency: the result computed from the inputs sampled at rising edge N appears on val2 after edge N and holds until edge N+1.
- rst high at a rising edge forces val2 = 32'h0000_0000, overriding any computation in that cycle. When rst is released, the first computed value appears after the next edge.
- Reset asserted mid-stream discards the in-flight result. There are no other internal state or handshakes.
- Simultaneous mem_read and mem_write are treated as a memory access (offset path).

## Structure
- Shared package `arm_pkg`:
  - shift-type constants SHIFT_LSL = 2'b00, SHIFT_LSR = 2'b01, SHIFT_ASR = 2'b10, SHIFT_ROR = 2'b11;
  - field-position constants for imm8, rotate, shift_imm and shift type.
- One sub-module, `val2_shifter`: a combinational 32-bit barrel shifter.
  - Inputs: data, 5-bit amount, 2-bit type.
  - Output: 32-bit result.
  - Used for both the immediate rotate (type ROR, amount {rot, 1'b0}) and the register shift.
- Top level: priority mux plus the output register.

## Test plan
All scenarios use reg2 = 32'hA892_3142, with reset applied first and val2 = 0 checked.
- mem_write = 1, imm = X, shift_operand = 12'hA2D -> val2 = 32'h0000_0A2D one cycle later. Repeat with mem_read = 1 for the same result.
- mem = 0, imm = 0, shift_operand = 12'hA2D (LSR #20) -> 32'h0000_0A89.
- imm = 0, shift_operand = 12'hA4D (ASR #20) -> 32'hFFFF_FA89. Then shift_operand = 12'hA6D (ROR #20) -> 32'h2314_2A89.
- imm = 0, shift_operand = 12'h200 (LSL #4) -> 32'h8923_1420. Then shift_operand = 12'h000 -> 32'hA892_3142 (amount 0 pass-through).
- imm = 1, shift_operand = 12'hA6D (0x6D ror 20) -> 32'h0006_D000. Then shift_operand = 12'h0FF -> 32'h0000_00FF, and 12'h1FF -> 32'hC000_003F.
- Drive a nonzero result, assert rst for one cycle with inputs unchanged -> val2 = 0 after that edge, then the nonzero value returns one edge after release.
